// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a register-file memory, with a configurable number of wait states
// per transfer and PSLVERR on out-of-range addresses.
module apb_slave_mem #(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam int unsigned IdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DepthLim = MEM_DEPTH[ADDR_WIDTH:0];
  localparam logic [3:0] WaitInit = WAIT_CYCLES[3:0];

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSetup  = 2'd1;
  localparam logic [1:0] StAccess = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [IdxW-1:0]       addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  write_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic            addr_err;
  logic [IdxW-1:0] addr_idx;
  logic            setup_accept;
  logic            xfer;
  logic            commit;

  assign addr_err     = {1'b0, PADDR} >= DepthLim;
  assign addr_idx     = PADDR[IdxW-1:0];
  assign setup_accept = (state_q == StIdle) && PSEL && !PENABLE;
  assign xfer         = PSEL && PENABLE;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    commit    = 1'b0;
    case (state_q)
      StIdle: begin
        if (setup_accept) begin
          state_d   = StSetup;
          cnt_d     = WaitInit;
          pready_d  = (WaitInit == 4'd0);
          pslverr_d = addr_err && (WaitInit == 4'd0);
          if (!PWRITE) prdata_d = addr_err ? '0 : mem_q[addr_idx];
        end
      end
      StSetup, StAccess: begin
        if (!xfer) begin
          // Master dropped the transfer: abort without committing.
          state_d   = StIdle;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else if (pready_q) begin
          commit    = write_q && !err_q;
          state_d   = StIdle;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else begin
          // Wait count runs from the setup->access edge; ready rises as it hits zero.
          state_d = StAccess;
          cnt_d   = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            pready_d  = 1'b1;
            pslverr_d = err_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      mem_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      if (setup_accept) begin
        addr_q  <= addr_idx;
        wdata_q <= PWDATA;
        write_q <= PWRITE;
        err_q   <= addr_err;
      end
      if (commit) mem_q[addr_q] <= wdata_q;
    end
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: three instances with 0, 2 and 3 wait states share the bus,
// each selected by its own PSEL.
module tb_apb_slave_mem;

  logic       clk = 1'b0;
  logic       presetn;
  logic       penable;
  logic       pwrite;
  logic [8:0] paddr;
  logic [7:0] pwdata;
  logic       psel    [3];
  logic       pready  [3];
  logic       pslverr [3];
  logic [7:0] prdata  [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  apb_slave_mem #(.WAIT_CYCLES(0)) u_w0 (
    .PCLK(clk), .PRESETn(presetn), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[0]), .PRDATA(prdata[0]),
    .PSLVERR(pslverr[0])
  );

  apb_slave_mem #(.WAIT_CYCLES(2)) u_w2 (
    .PCLK(clk), .PRESETn(presetn), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[1]), .PRDATA(prdata[1]),
    .PSLVERR(pslverr[1])
  );

  apb_slave_mem #(.WAIT_CYCLES(3)) u_w3 (
    .PCLK(clk), .PRESETn(presetn), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[2]), .PRDATA(prdata[2]),
    .PSLVERR(pslverr[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the completion edge with the bus idle.
  task automatic xfer(input int d, input logic wr, input logic [8:0] a, input logic [7:0] wd,
                      input int exp_wait, input logic [7:0] exp_rd, input logic exp_err,
                      input string tag);
    int waits;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    waits = 0;
    while (!pready[d] && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    check({tag, "_wait"}, 32'(waits), 32'(exp_wait));
    check({tag, "_err"}, 32'(pslverr[d]), 32'(exp_err));
    if (!wr) check({tag, "_rdata"}, 32'(prdata[d]), 32'(exp_rd));
    @(posedge clk); #1;
    psel[d] = 1'b0;
    penable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    presetn = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    for (int i = 0; i < 3; i++) psel[i] = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    presetn = 1'b1;
    check("rst_pready", 32'(pready[0]), 32'd0);
    check("rst_pslverr", 32'(pslverr[0]), 32'd0);
    check("rst_prdata", 32'(prdata[0]), 32'd0);
    check("rst_prdata_w3", 32'(prdata[2]), 32'd0);
    xfer(0, 1'b0, 9'h005, 8'h00, 0, 8'h00, 1'b0, "rst_rd5");

    // Zero wait states
    xfer(0, 1'b1, 9'h010, 8'hA5, 0, 8'h00, 1'b0, "w0_wr10");
    xfer(0, 1'b0, 9'h010, 8'h00, 0, 8'hA5, 1'b0, "w0_rd10");
    idle(1);

    // Three wait states, top valid address
    xfer(2, 1'b1, 9'h0FF, 8'h3C, 3, 8'h00, 1'b0, "w3_wrFF");
    xfer(2, 1'b0, 9'h0FF, 8'h00, 3, 8'h3C, 1'b0, "w3_rdFF");
    idle(1);

    // Out-of-range access must not alias onto word 0
    xfer(0, 1'b1, 9'h000, 8'h5A, 0, 8'h00, 1'b0, "err_wr00");
    xfer(0, 1'b1, 9'h100, 8'h77, 0, 8'h00, 1'b1, "err_wr100");
    check("err_idle_pready", 32'(pready[0]), 32'd0);
    check("err_idle_pslverr", 32'(pslverr[0]), 32'd0);
    xfer(0, 1'b0, 9'h100, 8'h00, 0, 8'h00, 1'b1, "err_rd100");
    xfer(0, 1'b0, 9'h000, 8'h00, 0, 8'h5A, 1'b0, "err_rd00");
    idle(1);

    // PSEL dropped during ACCESS
    xfer(1, 1'b1, 9'h020, 8'h44, 2, 8'h00, 1'b0, "w2_wr20");
    psel[1] = 1'b1;
    pwrite  = 1'b1;
    paddr   = 9'h020;
    pwdata  = 8'h11;
    penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check("abort_acc1_pready", 32'(pready[1]), 32'd0);
    @(posedge clk); #1;
    psel[1] = 1'b0;
    penable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("abort_no_ready%0d", k), 32'(pready[1]), 32'd0);
    end
    @(posedge clk); #1;
    xfer(1, 1'b0, 9'h020, 8'h00, 2, 8'h44, 1'b0, "abort_rd20");

    // Reset in the middle of ACCESS
    psel[1] = 1'b1;
    pwrite  = 1'b1;
    paddr   = 9'h020;
    pwdata  = 8'h99;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    presetn = 1'b0;
    psel[1] = 1'b0;
    penable = 1'b0;
    idle(2);
    presetn = 1'b1;
    check("rstab_pready", 32'(pready[1]), 32'd0);
    check("rstab_prdata", 32'(prdata[1]), 32'd0);
    xfer(1, 1'b0, 9'h020, 8'h00, 2, 8'h00, 1'b0, "rstab_rd20");
    xfer(0, 1'b0, 9'h010, 8'h00, 0, 8'h00, 1'b0, "rstab_rd10");

    // Back-to-back, no idle between transfers
    xfer(0, 1'b1, 9'h001, 8'h11, 0, 8'h00, 1'b0, "b2b_wr1");
    xfer(0, 1'b1, 9'h002, 8'h22, 0, 8'h00, 1'b0, "b2b_wr2");
    xfer(0, 1'b0, 9'h001, 8'h00, 0, 8'h11, 1'b0, "b2b_rd1");
    xfer(0, 1'b0, 9'h002, 8'h00, 0, 8'h22, 1'b0, "b2b_rd2");
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
